// File: rtl/fc_alu_sequencer_if.sv
// fc_alu_sequencer_if: bundles the layer control, memory read, ALU and output stream
//   signals of the FC ALU sequencer.
//   control : start, num_neurons, base_addr -> busy, done
//   memory  : mem_rd_req, mem_rd_addr -> mem_rd_valid, mem_rd_data
//   alu     : alu_values, alu_load_enable, alu_enable, alu_clear -> alu_value
//   stream  : out_valid, out_data, out_index -> out_ready
//   modport master = sequencer side, slave = environment side.
interface fc_alu_sequencer_if #(
   parameter int SIZE     = 16,
   parameter int INPUT_SZ = 2,
   parameter int NEURON_W = 6,
   parameter int MEM_AW   = 8
);
   logic                         start;
   logic [NEURON_W-1:0]          num_neurons;
   logic [MEM_AW-1:0]            base_addr;
   logic                         busy;
   logic                         done;
   logic                         mem_rd_req;
   logic [MEM_AW-1:0]            mem_rd_addr;
   logic                         mem_rd_valid;
   logic [(INPUT_SZ+1)*SIZE-1:0] mem_rd_data;
   logic [(INPUT_SZ+1)*SIZE-1:0] alu_values;
   logic [1:0]                   alu_load_enable;
   logic                         alu_enable;
   logic                         alu_clear;
   logic [SIZE-1:0]              alu_value;
   logic                         out_valid;
   logic                         out_ready;
   logic [SIZE-1:0]              out_data;
   logic [NEURON_W-1:0]          out_index;
   modport master (
      input  start, num_neurons, base_addr, mem_rd_valid, mem_rd_data, alu_value, out_ready,
      output busy, done, mem_rd_req, mem_rd_addr, alu_values, alu_load_enable, alu_enable,
             alu_clear, out_valid, out_data, out_index
   );
   modport slave (
      output start, num_neurons, base_addr, mem_rd_valid, mem_rd_data, alu_value, out_ready,
      input  busy, done, mem_rd_req, mem_rd_addr, alu_values, alu_load_enable, alu_enable,
             alu_clear, out_valid, out_data, out_index
   );
endinterface

// File: rtl/fc_alu_sequencer.sv
// fc_alu_sequencer: runs one FC layer on the FC ALU -- fetches the input vector once,
//   then per neuron fetches bias+weights, loads the ALU, captures and streams the result.
//   clk, rst (sync, active-high) plain ports; everything else on bus (master modport):
//   start/num_neurons/base_addr in, busy/done out; mem_rd_req/addr out, mem_rd_valid/data in;
//   alu_values/alu_load_enable/alu_enable/alu_clear out, alu_value in;
//   out_valid/out_data/out_index out, out_ready in.
//   Optional macro FC_SEQ_RELU_EN: clamp negative ALU results to zero at capture.
module fc_alu_sequencer #(
   parameter int SIZE     = 16,
   parameter int INPUT_SZ = 2,
   parameter int NEURON_W = 6,
   parameter int MEM_AW   = 8
) (
   input logic              clk,
   input logic              rst,
   fc_alu_sequencer_if.master bus
);
   typedef enum logic [3:0] {IDLE, CLR, FETCH_V, LOAD_V, FETCH_WB, LOAD_WB, WAIT, EMIT, FIN} state_t;
   state_t              state, state_nx;
   logic [NEURON_W:0]   n;
   logic [NEURON_W-1:0] num_q;
   logic [MEM_AW-1:0]   base_q;
   logic [SIZE-1:0]     res;
   logic                fetching, rd_ok, fire, last;
   assign fetching = state == FETCH_V || state == FETCH_WB;
   assign rd_ok    = fetching && bus.mem_rd_valid;
   assign fire     = state == EMIT && bus.out_ready;
   // n is one bit wider than the count so n+1 never aliases back onto a small num_q
   assign last     = n + (NEURON_W+1)'(1) == {1'b0, num_q};
`ifdef FC_SEQ_RELU_EN
   assign res = bus.alu_value[SIZE-1] ? '0 : bus.alu_value;
`else
   assign res = bus.alu_value;
`endif
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     state_nx = bus.start ? CLR : IDLE;
         CLR:      state_nx = num_q == '0 ? FIN : FETCH_V;
         FETCH_V:  state_nx = rd_ok ? LOAD_V : FETCH_V;
         LOAD_V:   state_nx = FETCH_WB;
         FETCH_WB: state_nx = rd_ok ? LOAD_WB : FETCH_WB;
         LOAD_WB:  state_nx = WAIT;
         WAIT:     state_nx = EMIT;
         EMIT:     state_nx = fire ? (last ? FIN : FETCH_WB) : EMIT;
         FIN:      state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end
   always_comb begin
      bus.busy            = state != IDLE;
      bus.done            = state == FIN;
      bus.mem_rd_req      = fetching;
      // the vector sits at base; neuron n's bias+weights at base+1+n, wrapping in MEM_AW bits
      bus.mem_rd_addr     = state == FETCH_V  ? base_q :
                            state == FETCH_WB ? base_q + MEM_AW'(n) + MEM_AW'(1) : '0;
      bus.alu_enable      = state == LOAD_V || state == LOAD_WB;
      bus.alu_load_enable = state == LOAD_V ? 2'd0 : state == LOAD_WB ? 2'd1 : 2'd2;
      bus.out_valid       = state == EMIT;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         n              <= '0;
         num_q          <= '0;
         base_q         <= '0;
         bus.alu_values <= '0;
         bus.alu_clear  <= 1'b1;
         bus.out_data   <= '0;
         bus.out_index  <= '0;
      end else begin
         bus.alu_clear <= state_nx == CLR;
         if (state == IDLE && bus.start) begin
            num_q  <= bus.num_neurons;
            base_q <= bus.base_addr;
            n      <= '0;
         end
         // the captured word feeds the ALU directly in the following load cycle
         if (rd_ok)
            bus.alu_values <= bus.mem_rd_data;
         if (state == WAIT) begin
            bus.out_data  <= res;
            bus.out_index <= n[NEURON_W-1:0];
         end
         if (fire)
            n <= n + (NEURON_W+1)'(1);
      end
   end
endmodule
